// File: rtl/carfield_region_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | carfield_region_decoder : programmable address-region table with a       |
// |                           one-stage valid/ready lookup and miss stats    |
// | Revision: 1.0                                                            |
// +----------------------------------------------------------------------------+
module carfield_region_decoder #(
    parameter int unsigned NumRules  = 8,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned IdxWidth  = 3,
    parameter int unsigned CntWidth  = 16,
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstStart = '0,
    parameter logic [NumRules-1:0][AddrWidth-1:0] RstEnd   = '0,
    parameter logic [NumRules-1:0][IdxWidth-1:0]  RstIdx   = '0,
    parameter logic [NumRules-1:0]                RstEn    = '0,
    parameter logic [IdxWidth-1:0]                MissIdx  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    // lookup request
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    // lookup response
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic                           resp_hit_o,
    output logic [IdxWidth-1:0]            resp_idx_o,
    // configuration port
    input  logic                           cfg_req_i,
    input  logic                           cfg_we_i,
    input  logic [$clog2(NumRules)+1:0]    cfg_addr_i,
    input  logic [AddrWidth-1:0]           cfg_wdata_i,
    output logic [AddrWidth-1:0]           cfg_rdata_o,
    output logic                           cfg_err_o,
    // miss statistics
    input  logic                           err_clear_i,
    output logic [CntWidth-1:0]            err_cnt_o,
    output logic                           err_valid_o,
    output logic [AddrWidth-1:0]           err_addr_o
);

    localparam int unsigned CfgAddrWidth = $clog2(NumRules) + 2;

    localparam logic [1:0] FIELD_START = 2'd0;
    localparam logic [1:0] FIELD_END   = 2'd1;
    localparam logic [1:0] FIELD_CTRL  = 2'd2;
    localparam logic [1:0] FIELD_RSVD  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NumRules-1:0][AddrWidth-1:0] rule_start_q, rule_start_d;
    logic [NumRules-1:0][AddrWidth-1:0] rule_end_q,   rule_end_d;
    logic [NumRules-1:0][IdxWidth-1:0]  rule_idx_q,   rule_idx_d;
    logic [NumRules-1:0]                rule_en_q,    rule_en_d;
    logic [NumRules-1:0]                rule_lock_q,  rule_lock_d;

    logic                               resp_valid_q, resp_valid_d;
    logic                               resp_hit_q,   resp_hit_d;
    logic [IdxWidth-1:0]                resp_idx_q,   resp_idx_d;

    logic [CntWidth-1:0]                err_cnt_q,    err_cnt_d;
    logic                               err_valid_q,  err_valid_d;
    logic [AddrWidth-1:0]               err_addr_q,   err_addr_d;

    // ------------------------------------------------------------------
    // Config decode
    // ------------------------------------------------------------------
    logic [CfgAddrWidth-1:0] cfg_rule_w;
    logic [1:0]              cfg_field_w;
    logic                    cfg_rule_ok_w;
    logic                    cfg_rsvd_w;
    logic                    cfg_wr_ok_w;
    logic [AddrWidth-1:0]    sel_start_w;
    logic [AddrWidth-1:0]    sel_end_w;
    logic [IdxWidth-1:0]     sel_idx_w;
    logic                    sel_en_w;
    logic                    sel_lock_w;
    logic [AddrWidth-1:0]    cfg_rdata_w;
    logic                    cfg_err_w;

    assign cfg_rule_w  = cfg_addr_i >> 2;
    assign cfg_field_w = cfg_addr_i[1:0];

    always_comb begin
        cfg_rule_ok_w = 1'b0;
        sel_start_w   = '0;
        sel_end_w     = '0;
        sel_idx_w     = '0;
        sel_en_w      = 1'b0;
        sel_lock_w    = 1'b0;
        // Matching by comparison keeps out-of-range rule numbers from indexing the table
        for (int r = 0; r < int'(NumRules); r++) begin
            if (cfg_rule_w == CfgAddrWidth'(r)) begin
                cfg_rule_ok_w = 1'b1;
                sel_start_w   = rule_start_q[r];
                sel_end_w     = rule_end_q[r];
                sel_idx_w     = rule_idx_q[r];
                sel_en_w      = rule_en_q[r];
                sel_lock_w    = rule_lock_q[r];
            end
        end

        cfg_rsvd_w = (cfg_field_w == FIELD_RSVD);

        cfg_rdata_w = '0;
        if (cfg_rule_ok_w) begin
            case (cfg_field_w)
                FIELD_START: cfg_rdata_w = sel_start_w;
                FIELD_END:   cfg_rdata_w = sel_end_w;
                FIELD_CTRL:  cfg_rdata_w = AddrWidth'({sel_lock_w, sel_en_w, sel_idx_w});
                default:     cfg_rdata_w = '0;
            endcase
        end

        cfg_err_w   = cfg_req_i && (!cfg_rule_ok_w || cfg_rsvd_w || (cfg_we_i && sel_lock_w));
        cfg_wr_ok_w = cfg_req_i && cfg_we_i && cfg_rule_ok_w && !cfg_rsvd_w && !sel_lock_w;
    end

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    always_comb begin
        rule_start_d = rule_start_q;
        rule_end_d   = rule_end_q;
        rule_idx_d   = rule_idx_q;
        rule_en_d    = rule_en_q;
        rule_lock_d  = rule_lock_q;
        for (int r = 0; r < int'(NumRules); r++) begin
            if (cfg_wr_ok_w && (cfg_rule_w == CfgAddrWidth'(r))) begin
                case (cfg_field_w)
                    FIELD_START: rule_start_d[r] = cfg_wdata_i;
                    FIELD_END:   rule_end_d[r]   = cfg_wdata_i;
                    FIELD_CTRL: begin
                        rule_idx_d[r]  = cfg_wdata_i[IdxWidth-1:0];
                        rule_en_d[r]   = cfg_wdata_i[IdxWidth];
                        rule_lock_d[r] = rule_lock_q[r] | cfg_wdata_i[IdxWidth+1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup: lowest-numbered enabled rule with start <= addr < end
    // ------------------------------------------------------------------
    logic                lookup_hit_w;
    logic [IdxWidth-1:0] lookup_idx_w;

    always_comb begin
        lookup_hit_w = 1'b0;
        lookup_idx_w = MissIdx;
        for (int r = 0; r < int'(NumRules); r++) begin
            if (!lookup_hit_w && rule_en_q[r] &&
                (rule_start_q[r] <= req_addr_i) && (req_addr_i < rule_end_q[r])) begin
                lookup_hit_w = 1'b1;
                lookup_idx_w = rule_idx_q[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response stage and miss statistics
    // ------------------------------------------------------------------
    logic req_ready_w;
    logic req_accept_w;
    logic lookup_miss_w;

    assign req_ready_w   = !resp_valid_q || resp_ready_i;
    assign req_accept_w  = req_valid_i && req_ready_w;
    assign lookup_miss_w = req_accept_w && !lookup_hit_w;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_hit_d   = resp_hit_q;
        resp_idx_d   = resp_idx_q;
        if (req_accept_w) begin
            resp_valid_d = 1'b1;
            resp_hit_d   = lookup_hit_w;
            resp_idx_d   = lookup_idx_w;
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clear_i) begin
            err_cnt_d   = '0;
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end
        // Applied after the clear so a same-cycle miss survives it
        if (lookup_miss_w) begin
            if (err_cnt_d != {CntWidth{1'b1}}) begin
                err_cnt_d = err_cnt_d + CntWidth'(1);
            end
            if (!err_valid_d) begin
                err_valid_d = 1'b1;
                err_addr_d  = req_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rule_start_q <= RstStart;
            rule_end_q   <= RstEnd;
            rule_idx_q   <= RstIdx;
            rule_en_q    <= RstEn;
            rule_lock_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= '0;
            err_cnt_q    <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            rule_start_q <= rule_start_d;
            rule_end_q   <= rule_end_d;
            rule_idx_q   <= rule_idx_d;
            rule_en_q    <= rule_en_d;
            rule_lock_q  <= rule_lock_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_idx_q   <= resp_idx_d;
            err_cnt_q    <= err_cnt_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign req_ready_o  = req_ready_w;
    assign resp_valid_o = resp_valid_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_idx_o   = resp_idx_q;
    assign cfg_rdata_o  = cfg_rdata_w;
    assign cfg_err_o    = cfg_err_w;
    assign err_cnt_o    = err_cnt_q;
    assign err_valid_o  = err_valid_q;
    assign err_addr_o   = err_addr_q;

endmodule
`default_nettype wire
